// File: rtl/mux_collector_16.sv
// mux_collector_16
//   16-to-1 collecting multiplexer. It gathers beats from 16 valid/ready sources
//   onto one registered output stream. OUT_SEL tags each beat with its source
//   index so that the sink can route it back through the 16-way demultiplexer.
//
//   Ports
//     clk_i        clock; all state changes on the rising edge
//     rst_i        asynchronous active-high reset; clears all state at once
//     enable_i     1 = new beats may be accepted
//     req_valid_i  bit i set = source i presents a beat
//     req_data_i   beat of source i at [i*DATA_WIDTH +: DATA_WIDTH]
//     req_ready_o  one-hot (or zero); the beat of that source is taken this cycle
//     out_valid_o  the output register holds a beat
//     out_data_o   registered beat
//     out_sel_o    source index of the beat in out_data_o
//     out_ready_i  the sink takes the output beat when out_valid_o & out_ready_i
//
//   Build option
//     FIXED_PRIORITY_EN  defined: fixed priority, source 0 highest, and no
//                        round-robin pointer. Undefined (default): round-robin.
module mux_collector_16 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic [15:0]              req_valid_i,
    input  logic [16*DATA_WIDTH-1:0] req_data_i,
    output logic [15:0]              req_ready_o,
    output logic                     out_valid_o,
    output logic [DATA_WIDTH-1:0]    out_data_o,
    output logic [3:0]               out_sel_o,
    input  logic                     out_ready_i
);

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [3:0]            out_sel_q, out_sel_d;
    logic [3:0]            grant;
    logic                  load;

    function automatic logic [3:0] lowest_idx(input logic [15:0] v);
        lowest_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) lowest_idx = 4'(i);
        end
    endfunction

`ifdef FIXED_PRIORITY_EN
    always_comb begin
        grant = lowest_idx(req_valid_i);
    end
`else
    logic [3:0]  ptr_q, ptr_d;
    logic [15:0] masked;

    // First pass looks only at sources at or above the pointer; if none are
    // valid, the second pass takes the lowest valid source, which wraps.
    always_comb begin
        masked = req_valid_i & (16'hFFFF << ptr_q);
        grant  = (|masked) ? lowest_idx(masked) : lowest_idx(req_valid_i);
    end

    always_comb begin
        ptr_d = load ? grant + 4'd1 : ptr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ptr_q <= 4'd0;
        else       ptr_q <= ptr_d;
    end
`endif

    // OUT_READY reaches only req_ready_o; the data path depends on the grant alone.
    // Gating with rst_i means no source is ever told "taken" while reset is asserted.
    always_comb begin
        load        = enable_i & (|req_valid_i) & (~out_valid_q | out_ready_i) & ~rst_i;
        req_ready_o = load ? (16'h0001 << grant) : 16'h0000;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = req_data_i[grant*DATA_WIDTH +: DATA_WIDTH];
            out_sel_d   = grant;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 4'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sel_o   = out_sel_q;

endmodule

// File: tb/tb_mux_collector_16.sv
module tb_mux_collector_16;

`ifdef FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic         clk, rst, enable, out_ready;
    logic [15:0]  req_valid;
    logic [127:0] req_data;
    logic [15:0]  req_ready;
    logic         out_valid;
    logic [7:0]   out_data;
    logic [3:0]   out_sel;

    int n_cmp = 0;
    int n_bad = 0;

    mux_collector_16 #(.DATA_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable),
        .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(req_ready), .out_valid_o(out_valid),
        .out_data_o(out_data), .out_sel_o(out_sel),
        .out_ready_i(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: output register contents plus rotating pointer.
    logic       m_valid;
    logic [7:0] m_data;
    int         m_sel;
    int         m_ptr;

    function automatic int pick(input logic [15:0] v, input int p);
        for (int k = 0; k < 16; k++) begin
            if (v[(p + k) % 16]) return (p + k) % 16;
        end
        return -1;
    endfunction

    function automatic bit m_load();
        return enable && (req_valid != 16'h0) && (!m_valid || out_ready);
    endfunction

    always @(posedge clk or posedge rst) begin
        int g;
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= 8'h00;
            m_sel   <= 0;
            m_ptr   <= 0;
        end else begin
            g = pick(req_valid, FIXED ? 0 : m_ptr);
            if (m_load()) begin
                m_valid <= 1'b1;
                m_data  <= req_data[g*8 +: 8];
                m_sel   <= g;
                m_ptr   <= FIXED ? 0 : (g + 1) % 16;
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] exp_rdy;
        exp_rdy = 16'h0;
        if (!rst && m_load()) exp_rdy = 16'h1 << pick(req_valid, FIXED ? 0 : m_ptr);
        check("model_ready", req_ready, exp_rdy);
        check("model_valid", out_valid, m_valid);
        check("model_data",  out_data,  m_data);
        check("model_sel",   out_sel,   m_sel);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd_data();
        logic [127:0] d;
        for (int i = 0; i < 4; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        logic [7:0] exp_d;
        rst = 1'b1; enable = 1'b1; out_ready = 1'b0;
        req_valid = 16'h0; req_data = '0;
        repeat (2) tick();
        req_valid = 16'hFFFF;
        req_data  = rnd_data();
        @(negedge clk);
        check("reset_valid", out_valid, 1'b0);
        check("reset_data",  out_data,  8'h00);
        check("reset_sel",   out_sel,   4'd0);
        check("reset_ready", req_ready, 16'h0);
        tick();
        rst = 1'b0; out_ready = 1'b1;

        // Round-robin sweep: 30 grants leave the pointer at 14.
        for (int i = 0; i < 30; i++) begin
            req_data = rnd_data();
            @(negedge clk);
            check("rr_ready", req_ready, FIXED ? 16'h1 : 16'h1 << (i % 16));
            tick();
            check("rr_valid", out_valid, 1'b1);
            check("rr_sel",   out_sel,   FIXED ? 0 : i % 16);
        end

        // Wrap and skip from pointer 14.
        req_valid = 16'h0003;
        @(negedge clk);
        check("wrap_ready0", req_ready, 16'h0001);
        tick();
        check("wrap_sel0", out_sel, 4'd0);
        @(negedge clk);
        check("wrap_ready1", req_ready, FIXED ? 16'h1 : 16'h2);
        tick();
        check("wrap_sel1", out_sel, FIXED ? 4'd0 : 4'd1);
        req_valid = 16'hFFFF;
        @(negedge clk);
        check("wrap_ptr2", req_ready, FIXED ? 16'h1 : 16'h4);
        tick();

        // Single source.
        req_valid = 16'h0020;
        req_data  = rnd_data();
        req_data[5*8 +: 8] = 8'hA5;
        @(negedge clk);
        check("single_ready", req_ready, 16'h0020);
        tick();
        check("single_valid", out_valid, 1'b1);
        check("single_data",  out_data,  8'hA5);
        check("single_sel",   out_sel,   4'd5);

        // Backpressure for five cycles, then release.
        out_ready = 1'b0;
        req_valid = 16'h0101;
        req_data  = rnd_data();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ready", req_ready, 16'h0);
            check("bp_data",  out_data,  8'hA5);
            check("bp_sel",   out_sel,   4'd5);
            check("bp_valid", out_valid, 1'b1);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", req_ready, FIXED ? 16'h0001 : 16'h0100);
        exp_d = FIXED ? req_data[7:0] : req_data[64 +: 8];
        tick();
        check("bp_release_sel",  out_sel,  FIXED ? 4'd0 : 4'd8);
        check("bp_release_data", out_data, exp_d);

        // Enable low: held beat drains, pointer holds at 9.
        enable = 1'b0;
        req_valid = 16'hFFFF;
        @(negedge clk);
        check("en_ready", req_ready, 16'h0);
        tick();
        check("en_drain", out_valid, 1'b0);
        enable = 1'b1;
        @(negedge clk);
        check("en_ptr", req_ready, FIXED ? 16'h1 : 16'h0200);
        tick();

        // Reset in the middle of a held beat.
        out_ready = 1'b0;
        check("mid_held", out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_sel",   out_sel,   4'd0);
        check("mid_rst_data",  out_data,  8'h00);
        check("mid_rst_ready", req_ready, 16'h0);
        tick();
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_grant", req_ready, 16'h0001);
        tick();
        check("post_rst_sel", out_sel, 4'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            enable    = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: req_valid = 16'h0;
                1: req_valid = 16'h1 << $urandom_range(0, 15);
                2: req_valid = 16'hFFFF;
                default: req_valid = 16'($urandom);
            endcase
            req_data = rnd_data();
            tick();
        end
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
